example_mul_share_arb: RTL
==========================

# example_mul_share_arb

Round-robin scheduler that shares one unsigned×signed DSP48 multiplier (11-bit unsigned × 14-bit signed) among N requesters. Each requester offers an operand pair on a valid/ready channel. One request is granted per cycle and pushed through a NUM_STAGE-deep pipeline around the shared multiplier. Each result is returned on a single valid/ready channel tagged with the requester index. The block sits between the HLS dataflow processes and the shared mul_mul DSP resource.

## Interface
- N, 4, number of requesters (2..8)
- A_W, 11, operand a width (unsigned)
- B_W, 14, operand b width (signed)
- P_W, 21, result width
- NUM_STAGE, 2, pipeline depth (1..4)
- ID_W, 2, tag width, = clog2(N)
- ap_clk  in  1  clock; all state changes on the rising edge
- ap_rst  in  1  reset, asynchronous, active-high
- req_valid  in  N  per-requester operand valid
- req_ready  out  N  per-requester accept, one-hot or zero
- req_a  in  N*A_W  requester i's a in bits [i*A_W +: A_W]
- req_b  in  N*B_W  requester i's b in bits [i*B_W +: B_W]
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_p  out  P_W  product
- res_id  out  ID_W  index of the requester that issued this result
- busy  out  1  high when any pipeline stage holds a valid entry

## Operation
- stall = res_valid & ~res_ready.
- Grant: when stall is low, grant the first requester with req_valid high, searching from ptr+1 upward with wrap-around modulo N. At most one grant per cycle.
- ptr holds the last granted index. It updates only on an accept, where an accept is req_valid[i] & req_ready[i].
- req_ready[i] = grant[i] & ~stall. It is combinational from req_valid and res_ready. A requester must not make req_valid depend on req_ready.
- Stage 1 captures a, b, id and a valid bit on an accept. If there is no accept and no stall, stage 1 loads a bubble (valid = 0).
- Stage k (k ≥ 2) captures stage k-1 when stall is low.
- Product: the full signed product is $signed({1'b0,a}) * $signed(b), A_W+B_W+1 bits wide.
  - It is computed from the stage-1 operands and registered into stage 2.
  - res_p is the low P_W bits of the product, two's-complement wrap, no saturation.
- NUM_STAGE = 1: res_p is the combinational product of the stage-1 registers.
- res_valid, res_p and res_id come from the last stage.
- Stall: when stall is high, every stage holds its contents, no grant is issued, ptr holds, and res_p/res_id stay stable.
- Bubbles are not collapsed; an invalid stage advances like a valid one.
- Results leave the pipeline in issue order.

## Timing
- Reset (ap_rst high, effective immediately):
  - all stage valids = 0, hence res_valid = 0 and busy = 0
  - ptr = N-1, so requester 0 has top priority after reset
  - res_p = 0, res_id = 0, req_ready = 0 while ap_rst is asserted
- Reset mid-operation: all in-flight entries are discarded with no result emitted. Requesters must re-present after ap_rst drops.
- Latency: an accept at edge t gives res_valid high after edge t+NUM_STAGE-1. This is NUM_STAGE cycles from request presentation to result.
- Throughput: one result per cycle when res_ready stays high.
- Fairness: a requester that holds req_valid high waits at most N-1 accepts of other requesters before it is granted.
- Simultaneous events:
  - res_ready low while requests are pending: no accept; req_ready stays 0 for the whole stall.
  - res_ready returning high: an accept is possible in that same cycle.
- Empty pipeline with res_ready low: stall = 0, so accepts continue until a valid entry reaches the last stage.

## Test plan
- Single op, NUM_STAGE=2: requester 2 presents a=100, b=-3 → req_ready[2] high the same cycle; one cycle later res_valid=1, res_p=-300, res_id=2.
- Wrap: a=2047, b=-8192 → res_p = +8192 (low 21 bits of -16769024). a=0, b=-8192 → res_p = 0.
- Round-robin: all 4 requesters hold valid, res_ready=1 → grant order 0,1,2,3,0,1 on consecutive cycles, and res_id follows the same order NUM_STAGE-1 cycles later.
- Backpressure: hold res_ready=0 for 5 cycles with a valid result present → res_p/res_id stable, req_ready all 0, ptr unchanged. On release, the results drain in order with none lost or duplicated.
- Reset mid-flight: with 2 entries in the pipeline, pulse ap_rst asynchronously between edges → res_valid and busy drop immediately and no stale result appears. After release, requester 0 is granted first when all requesters are valid.
- Sparse traffic: requester 3 only, valid every third cycle → each is accepted immediately; res_valid pulses are single cycles; busy deasserts when the pipeline is empty.

Source files
------------

// File: rtl/example_mul_share_arb.sv
// Round-robin arbiter sharing one unsigned x signed multiplier among N requesters.
// Granted operands flow through a NUM_STAGE pipeline and return tagged with the requester index.
module example_mul_share_arb #(
    parameter int N         = 4,
    parameter int A_W       = 11,
    parameter int B_W       = 14,
    parameter int P_W       = 21,
    parameter int NUM_STAGE = 2,
    parameter int ID_W      = $clog2(N)
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic [N-1:0]       req_valid,
    output logic [N-1:0]       req_ready,
    input  logic [N*A_W-1:0]   req_a,
    input  logic [N*B_W-1:0]   req_b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [P_W-1:0]     res_p,
    output logic [ID_W-1:0]    res_id,
    output logic               busy
);

    localparam int PROD_W = A_W + B_W + 1;

    logic                     stall;
    logic                     accept;
    logic                     search_hit;
    logic [ID_W-1:0]          search_idx;
    logic [N-1:0]             grant;
    logic [ID_W-1:0]          grant_idx;
    logic [ID_W-1:0]          ptr;
    logic [A_W-1:0]           sel_a;
    logic [B_W-1:0]           sel_b;

    logic [NUM_STAGE-1:0]     vld;
    logic [ID_W-1:0]          id_pipe [NUM_STAGE];
    logic [A_W-1:0]           s1_a;
    logic signed [B_W-1:0]    s1_b;

    logic signed [PROD_W-1:0] op_a_ext;
    logic signed [PROD_W-1:0] op_b_ext;
    logic [P_W-1:0]           mul_p;

    assign res_valid = vld[NUM_STAGE-1];
    assign res_id    = id_pipe[NUM_STAGE-1];
    assign busy      = |vld;
    assign stall     = res_valid & ~res_ready;

    // Search starts one past the last granted index and wraps modulo N.
    always_comb begin
        grant      = '0;
        grant_idx  = '0;
        search_hit = 1'b0;
        search_idx = '0;
        for (int o = 1; o <= N; o++) begin
            search_idx = ID_W'((int'(ptr) + o) % N);
            if (!search_hit && req_valid[search_idx]) begin
                grant[search_idx] = 1'b1;
                grant_idx         = search_idx;
                search_hit        = 1'b1;
            end
        end
    end

    assign req_ready = (ap_rst || stall) ? '0 : grant;
    assign accept    = |req_ready;
    assign sel_a     = req_a[grant_idx*A_W +: A_W];
    assign sel_b     = req_b[grant_idx*B_W +: B_W];

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            ptr  <= ID_W'(N - 1);
            vld  <= '0;
            s1_a <= '0;
            s1_b <= '0;
            for (int k = 0; k < NUM_STAGE; k++) begin
                id_pipe[k] <= '0;
            end
        end else if (!stall) begin
            vld[0] <= accept;
            for (int k = 1; k < NUM_STAGE; k++) begin
                vld[k]     <= vld[k-1];
                id_pipe[k] <= id_pipe[k-1];
            end
            if (accept) begin
                ptr        <= grant_idx;
                s1_a       <= sel_a;
                s1_b       <= sel_b;
                id_pipe[0] <= grant_idx;
            end
        end
    end

    // Zero-extend a to make it a non-negative signed operand; only the low P_W bits are kept.
    assign op_a_ext = PROD_W'($signed({1'b0, s1_a}));
    assign op_b_ext = PROD_W'(s1_b);
    assign mul_p    = P_W'(op_a_ext * op_b_ext);

    if (NUM_STAGE == 1) begin : g_comb_out
        assign res_p = mul_p;
    end else begin : g_reg_out
        logic [P_W-1:0] p_pipe [1:NUM_STAGE-1];

        always_ff @(posedge ap_clk or posedge ap_rst) begin
            if (ap_rst) begin
                for (int k = 1; k < NUM_STAGE; k++) begin
                    p_pipe[k] <= '0;
                end
            end else if (!stall) begin
                p_pipe[1] <= mul_p;
                for (int k = 2; k < NUM_STAGE; k++) begin
                    p_pipe[k] <= p_pipe[k-1];
                end
            end
        end

        assign res_p = p_pipe[NUM_STAGE-1];
    end

endmodule
